edp_slice_n: RTL and testbench

EDP_SLICE_N -- requirements
Module: edp_slice_n

---
 rtl/edp_slice_n.sv | 223 ++++++++++++++++++++++
 tb/tb_edp_slice_n.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edp_slice_n.sv
// EDP data-path slice: AR/ARX/BR/BRX/MQ registers, AD/ADX adders,
// parity-protected fast memory and EBUS driver. Bit 0 is the most
// significant bit; left shifts move toward bit 0 (the vector MSB).
module edp_slice_n #(
   parameter int WIDTH     = 6,
   parameter int FM_BLOCKS = 8
) (
   input  logic                         clk_edp_h,
   input  logic                         reset_h,
   input  logic [WIDTH-1:0]             cache_data_h,
   input  logic [WIDTH-1:0]             sh_h,
   input  logic [WIDTH-1:0]             armm_h,
   input  logic [WIDTH-1:0]             vma_held_or_pc_h,
   input  logic [2:0]                   ar_sel_h,
   input  logic [1:0]                   arx_sel_h,
   input  logic [1:0]                   mq_sel_h,
   input  logic                         br_load_h,
   input  logic                         brx_load_h,
   input  logic [1:0]                   ada_sel_h,
   input  logic                         ada_dis_h,
   input  logic [1:0]                   adb_sel_h,
   input  logic                         ad_boole_h,
   input  logic [3:0]                   ad_func_h,
   input  logic                         ad_cry_in_h,
   input  logic                         adx_cry_in_h,
   input  logic                         shift_in_h,
   input  logic                         mq_shift_in_h,
   input  logic [3:0]                   fm_adr_h,
   input  logic [$clog2(FM_BLOCKS)-1:0] fm_block_h,
   input  logic                         fm_write_h,
   input  logic                         fm_par_inject_h,
   input  logic                         fm_par_err_clr_h,
   input  logic                         ebus_drv_h,
   input  logic [2:0]                   ebus_sel_h,
   output logic [WIDTH-1:0]             ar_h,
   output logic [WIDTH-1:0]             arx_h,
   output logic [WIDTH-1:0]             br_h,
   output logic [WIDTH-1:0]             brx_h,
   output logic [WIDTH-1:0]             mq_h,
   output logic [WIDTH-1:0]             ad_h,
   output logic [WIDTH-1:0]             adx_h,
   output logic [WIDTH-1:0]             fm_data_h,
   output logic [WIDTH-1:0]             ebus_d_h,
   output logic                         ad_cry_out_h,
   output logic                         adx_cry_out_h,
   output logic                         ad_cg_h,
   output logic                         ad_cp_h,
   output logic                         ad_overflow_h,
   output logic                         ad_eq0_l,
   output logic                         fm_parity_h,
   output logic                         fm_par_err_h
);

   localparam int AW    = $clog2(FM_BLOCKS) + 4;
   localparam int DEPTH = FM_BLOCKS * 16;

   // Odd parity bit: makes data plus parity contain an odd number of ones.
   function automatic logic odd_par(input logic [WIDTH-1:0] d);
      return ~(^d);
   endfunction

   logic [WIDTH-1:0] r_ar, r_arx, r_br, r_brx, r_mq, r_fm_data;
   logic             r_fm_par, r_fm_err;
   logic [WIDTH:0]   r_fm_mem [0:DEPTH-1];

   logic [WIDTH-1:0] w_a, w_b, w_bm, w_ad_bool, w_adx_bool, w_ad, w_ad_shl, w_ebus;
   logic [WIDTH:0]   w_sum, w_gsum, w_xsum;
   logic [WIDTH-1:0] w_low;
   logic [AW-1:0]    w_fm_addr;
   logic [WIDTH:0]   w_fm_wword, w_fm_rword;
   logic             w_fm_bad;

   // Adder operand selection; B is complemented for arithmetic when func[0] is set.
   always_comb begin
      w_a = {WIDTH{1'b0}};
      w_b = {WIDTH{1'b0}};
      if (ada_dis_h) begin
         w_a = {WIDTH{1'b0}};
      end else begin
         case (ada_sel_h)
            2'd0:    w_a = r_ar;
            2'd1:    w_a = r_arx;
            2'd2:    w_a = r_mq;
            default: w_a = vma_held_or_pc_h;
         endcase
      end
      case (adb_sel_h)
         2'd0:    w_b = r_br;
         2'd1:    w_b = {r_br[WIDTH-2:0], shift_in_h};
         2'd2:    w_b = r_ar;
         default: w_b = r_fm_data;
      endcase
      w_bm = ad_func_h[0] ? ~w_b : w_b;
   end

   // Bitwise boolean functions: func is a truth table indexed by {A,B}.
   always_comb begin
      w_ad_bool  = {WIDTH{1'b0}};
      w_adx_bool = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         w_ad_bool[i]  = ad_func_h[{w_a[i], w_b[i]}];
         w_adx_bool[i] = ad_func_h[{r_arx[i], r_brx[i]}];
      end
   end

   assign w_sum  = {1'b0, w_a} + {1'b0, w_bm} + {{WIDTH{1'b0}}, ad_cry_in_h};
   assign w_gsum = {1'b0, w_a} + {1'b0, w_bm};
   // Sum of all bits below the MSB; its top bit is the carry into the MSB.
   assign w_low  = {1'b0, w_a[WIDTH-2:0]} + {1'b0, w_bm[WIDTH-2:0]}
                 + {{(WIDTH-1){1'b0}}, ad_cry_in_h};
   assign w_xsum = {1'b0, r_arx} + {1'b0, r_brx} + {{WIDTH{1'b0}}, adx_cry_in_h};

   assign w_ad          = ad_boole_h ? w_ad_bool : w_sum[WIDTH-1:0];
   assign w_ad_shl      = {w_ad[WIDTH-2:0], shift_in_h};
   assign ad_h          = w_ad;
   assign ad_cry_out_h  = ad_boole_h ? 1'b0 : w_sum[WIDTH];
   assign ad_cg_h       = ad_boole_h ? 1'b0 : w_gsum[WIDTH];
   assign ad_cp_h       = ad_boole_h ? 1'b0 : &(w_a ^ w_bm);
   assign ad_overflow_h = ad_boole_h ? 1'b0 : (w_low[WIDTH-1] ^ w_sum[WIDTH]);
   assign ad_eq0_l      = |w_ad;
   assign adx_h         = ad_boole_h ? w_adx_bool : w_xsum[WIDTH-1:0];
   assign adx_cry_out_h = ad_boole_h ? 1'b0 : w_xsum[WIDTH];

   // Fast memory: write word carries AD plus (optionally corrupted) parity;
   // a read of the word being written returns the new word.
   assign w_fm_addr  = {fm_block_h, fm_adr_h};
   assign w_fm_wword = {odd_par(w_ad) ^ fm_par_inject_h, w_ad};
   assign w_fm_rword = fm_write_h ? w_fm_wword : r_fm_mem[w_fm_addr];
   assign w_fm_bad   = w_fm_rword[WIDTH] != odd_par(w_fm_rword[WIDTH-1:0]);

   // Fast-memory array write; contents survive reset, writes blocked during reset.
   always_ff @(posedge clk_edp_h) begin
      if (!reset_h && fm_write_h) begin
         r_fm_mem[w_fm_addr] <= w_fm_wword;
      end
   end

   // Data-path registers, registered FM read and sticky parity error.
   always_ff @(posedge clk_edp_h) begin
      if (reset_h) begin
         r_ar      <= {WIDTH{1'b0}};
         r_arx     <= {WIDTH{1'b0}};
         r_br      <= {WIDTH{1'b0}};
         r_brx     <= {WIDTH{1'b0}};
         r_mq      <= {WIDTH{1'b0}};
         r_fm_data <= {WIDTH{1'b0}};
         r_fm_par  <= 1'b0;
         r_fm_err  <= 1'b0;
      end else begin
         case (ar_sel_h)
            3'd0:    r_ar <= r_ar;
            3'd1:    r_ar <= cache_data_h;
            3'd2:    r_ar <= w_ad;
            3'd3:    r_ar <= sh_h;
            3'd4:    r_ar <= armm_h;
            3'd5:    r_ar <= vma_held_or_pc_h;
            3'd6:    r_ar <= w_ad_shl;
            default: r_ar <= {WIDTH{1'b0}};
         endcase
         case (arx_sel_h)
            2'd0:    r_arx <= r_arx;
            2'd1:    r_arx <= cache_data_h;
            2'd2:    r_arx <= adx_h;
            default: r_arx <= r_mq;
         endcase
         case (mq_sel_h)
            2'd0:    r_mq <= r_mq;
            2'd1:    r_mq <= {r_mq[WIDTH-2:0], mq_shift_in_h};
            2'd2:    r_mq <= w_ad;
            default: r_mq <= r_arx;
         endcase
         if (br_load_h) begin
            r_br <= r_ar;
         end else begin
            r_br <= r_br;
         end
         if (brx_load_h) begin
            r_brx <= r_arx;
         end else begin
            r_brx <= r_brx;
         end
         r_fm_data <= w_fm_rword[WIDTH-1:0];
         r_fm_par  <= w_fm_rword[WIDTH];
         if (w_fm_bad) begin
            r_fm_err <= 1'b1;
         end else if (fm_par_err_clr_h) begin
            r_fm_err <= 1'b0;
         end else begin
            r_fm_err <= r_fm_err;
         end
      end
   end

   // EBUS source multiplexer, zero when not driving.
   always_comb begin
      w_ebus = {WIDTH{1'b0}};
      if (ebus_drv_h) begin
         case (ebus_sel_h)
            3'd0:    w_ebus = r_ar;
            3'd1:    w_ebus = r_arx;
            3'd2:    w_ebus = r_br;
            3'd3:    w_ebus = r_brx;
            3'd4:    w_ebus = r_mq;
            3'd5:    w_ebus = w_ad;
            3'd6:    w_ebus = r_fm_data;
            default: w_ebus = {WIDTH{1'b0}};
         endcase
      end else begin
         w_ebus = {WIDTH{1'b0}};
      end
   end

   assign ar_h         = r_ar;
   assign arx_h        = r_arx;
   assign br_h         = r_br;
   assign brx_h        = r_brx;
   assign mq_h         = r_mq;
   assign fm_data_h    = r_fm_data;
   assign fm_parity_h  = r_fm_par;
   assign fm_par_err_h = r_fm_err;
   assign ebus_d_h     = w_ebus;

endmodule

// File: tb/tb_edp_slice_n.sv
// Randomized bench for edp_slice_n against a behavioural model, plus
// directed boundary cases; a second 36-bit instance covers wide MQ shifting.
module tb_edp_slice_n;
   localparam int W    = 6;
   localparam int WL   = 36;
   localparam int MASK = (1 << W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_h;
   logic [W-1:0]  cache_s, sh_s, armm_s, vma_s;
   logic [WL-1:0] cache_l, sh_l, armm_l, vma_l;
   logic [2:0]    ar_sel, ebus_sel, fm_blk;
   logic [1:0]    arx_sel, mq_sel, ada_sel, adb_sel;
   logic          br_load, brx_load, ada_dis, boole, cin, xcin, shin, mqin;
   logic [3:0]    func, fm_adr;
   logic          fm_wr, fm_inj, fm_clr, ebus_drv;

   logic [W-1:0]  ar, arx, br, brx, mq, ad, adx, fm_data, ebus;
   logic          cout, xcout, cg, cp, ovf, eq0_l, fm_par, fm_err;
   logic [WL-1:0] l_ar, l_arx, l_br, l_brx, l_mq, l_ad, l_adx, l_fm_data, l_ebus;
   logic          l_cout, l_xcout, l_cg, l_cp, l_ovf, l_eq0_l, l_fm_par, l_fm_err;

   edp_slice_n #(.WIDTH(W), .FM_BLOCKS(8)) dut (
      .clk_edp_h(clk), .reset_h(reset_h), .cache_data_h(cache_s), .sh_h(sh_s),
      .armm_h(armm_s), .vma_held_or_pc_h(vma_s), .ar_sel_h(ar_sel), .arx_sel_h(arx_sel),
      .mq_sel_h(mq_sel), .br_load_h(br_load), .brx_load_h(brx_load), .ada_sel_h(ada_sel),
      .ada_dis_h(ada_dis), .adb_sel_h(adb_sel), .ad_boole_h(boole), .ad_func_h(func),
      .ad_cry_in_h(cin), .adx_cry_in_h(xcin), .shift_in_h(shin), .mq_shift_in_h(mqin),
      .fm_adr_h(fm_adr), .fm_block_h(fm_blk), .fm_write_h(fm_wr), .fm_par_inject_h(fm_inj),
      .fm_par_err_clr_h(fm_clr), .ebus_drv_h(ebus_drv), .ebus_sel_h(ebus_sel),
      .ar_h(ar), .arx_h(arx), .br_h(br), .brx_h(brx), .mq_h(mq), .ad_h(ad), .adx_h(adx),
      .fm_data_h(fm_data), .ebus_d_h(ebus), .ad_cry_out_h(cout), .adx_cry_out_h(xcout),
      .ad_cg_h(cg), .ad_cp_h(cp), .ad_overflow_h(ovf), .ad_eq0_l(eq0_l),
      .fm_parity_h(fm_par), .fm_par_err_h(fm_err));

   edp_slice_n #(.WIDTH(WL), .FM_BLOCKS(8)) dut_l (
      .clk_edp_h(clk), .reset_h(reset_h), .cache_data_h(cache_l), .sh_h(sh_l),
      .armm_h(armm_l), .vma_held_or_pc_h(vma_l), .ar_sel_h(ar_sel), .arx_sel_h(arx_sel),
      .mq_sel_h(mq_sel), .br_load_h(br_load), .brx_load_h(brx_load), .ada_sel_h(ada_sel),
      .ada_dis_h(ada_dis), .adb_sel_h(adb_sel), .ad_boole_h(boole), .ad_func_h(func),
      .ad_cry_in_h(cin), .adx_cry_in_h(xcin), .shift_in_h(shin), .mq_shift_in_h(mqin),
      .fm_adr_h(fm_adr), .fm_block_h(fm_blk), .fm_write_h(fm_wr), .fm_par_inject_h(fm_inj),
      .fm_par_err_clr_h(fm_clr), .ebus_drv_h(ebus_drv), .ebus_sel_h(ebus_sel),
      .ar_h(l_ar), .arx_h(l_arx), .br_h(l_br), .brx_h(l_brx), .mq_h(l_mq), .ad_h(l_ad),
      .adx_h(l_adx), .fm_data_h(l_fm_data), .ebus_d_h(l_ebus), .ad_cry_out_h(l_cout),
      .adx_cry_out_h(l_xcout), .ad_cg_h(l_cg), .ad_cp_h(l_cp), .ad_overflow_h(l_ovf),
      .ad_eq0_l(l_eq0_l), .fm_parity_h(l_fm_par), .fm_par_err_h(l_fm_err));

   // Reference model state (6-bit instance)
   logic [W-1:0] m_ar, m_arx, m_br, m_brx, m_mq, m_fd;
   logic         m_fp, m_fe;
   logic [W:0]   m_mem [0:127];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Adder results computed with plain integer arithmetic
   task automatic model_alu(output logic [W-1:0] e_ad, output logic [W-1:0] e_adx,
                            output logic e_co, output logic e_xco, output logic e_cg,
                            output logic e_cp, output logic e_ov);
      int a, b, bm, s, x;
      case (ada_sel)
         2'd0:    a = int'(m_ar);
         2'd1:    a = int'(m_arx);
         2'd2:    a = int'(m_mq);
         default: a = int'(vma_s);
      endcase
      if (ada_dis) a = 0;
      case (adb_sel)
         2'd0:    b = int'(m_br);
         2'd1:    b = (int'(m_br) * 2 + int'(shin)) & MASK;
         2'd2:    b = int'(m_ar);
         default: b = int'(m_fd);
      endcase
      bm = func[0] ? (MASK - b) : b;
      if (boole) begin
         for (int i = 0; i < W; i++) begin
            e_ad[i]  = func[{a[i], b[i]}];
            e_adx[i] = func[{m_arx[i], m_brx[i]}];
         end
         e_co = 1'b0; e_xco = 1'b0; e_cg = 1'b0; e_cp = 1'b0; e_ov = 1'b0;
      end else begin
         s     = a + bm + int'(cin);
         e_ad  = s[W-1:0];
         e_co  = (s > MASK);
         e_cg  = ((a + bm) > MASK);
         e_cp  = ((a ^ bm) == MASK);
         e_ov  = (a[W-1] == bm[W-1]) && (s[W-1] != a[W-1]);
         x     = int'(m_arx) + int'(m_brx) + int'(xcin);
         e_adx = x[W-1:0];
         e_xco = (x > MASK);
      end
   endtask

   // One clock: check all outputs at negedge, advance model across posedge
   task automatic cycle();
      logic [W-1:0] e_ad, e_adx, e_eb, n_ar, n_arx, n_br, n_brx, n_mq, n_fd;
      logic         e_co, e_xco, e_cg, e_cp, e_ov, n_fp, n_fe, bad;
      logic [W:0]   wword, rword;
      int           addr;
      @(negedge clk);
      model_alu(e_ad, e_adx, e_co, e_xco, e_cg, e_cp, e_ov);
      e_eb = '0;
      if (ebus_drv) begin
         case (ebus_sel)
            3'd0: e_eb = m_ar;   3'd1: e_eb = m_arx; 3'd2: e_eb = m_br;
            3'd3: e_eb = m_brx;  3'd4: e_eb = m_mq;  3'd5: e_eb = e_ad;
            3'd6: e_eb = m_fd;   default: e_eb = '0;
         endcase
      end
      check_eq("ar", ar, m_ar);          check_eq("arx", arx, m_arx);
      check_eq("br", br, m_br);          check_eq("brx", brx, m_brx);
      check_eq("mq", mq, m_mq);          check_eq("fm_data", fm_data, m_fd);
      check_eq("fm_parity", fm_par, m_fp); check_eq("fm_par_err", fm_err, m_fe);
      check_eq("ad", ad, e_ad);          check_eq("adx", adx, e_adx);
      check_eq("ad_cry_out", cout, e_co); check_eq("adx_cry_out", xcout, e_xco);
      check_eq("ad_cg", cg, e_cg);       check_eq("ad_cp", cp, e_cp);
      check_eq("ad_overflow", ovf, e_ov); check_eq("ad_eq0_l", eq0_l, e_ad != '0);
      check_eq("ebus", ebus, e_eb);
      n_ar = m_ar; n_arx = m_arx; n_br = m_br; n_brx = m_brx; n_mq = m_mq;
      n_fd = m_fd; n_fp = m_fp; n_fe = m_fe;
      addr  = int'(fm_blk) * 16 + int'(fm_adr);
      wword = {(($countones(e_ad) % 2) == 0) ^ fm_inj, e_ad};
      if (reset_h) begin
         n_ar = '0; n_arx = '0; n_br = '0; n_brx = '0; n_mq = '0;
         n_fd = '0; n_fp = 1'b0; n_fe = 1'b0;
      end else begin
         case (ar_sel)
            3'd0: n_ar = m_ar;  3'd1: n_ar = cache_s; 3'd2: n_ar = e_ad;
            3'd3: n_ar = sh_s;  3'd4: n_ar = armm_s;  3'd5: n_ar = vma_s;
            3'd6: n_ar = W'((int'(e_ad) * 2 + int'(shin)) & MASK);
            default: n_ar = '0;
         endcase
         case (arx_sel)
            2'd0: n_arx = m_arx; 2'd1: n_arx = cache_s; 2'd2: n_arx = e_adx; default: n_arx = m_mq;
         endcase
         case (mq_sel)
            2'd0: n_mq = m_mq;
            2'd1: n_mq = W'((int'(m_mq) * 2 + int'(mqin)) & MASK);
            2'd2: n_mq = e_ad;
            default: n_mq = m_arx;
         endcase
         if (br_load)  n_br  = m_ar;
         if (brx_load) n_brx = m_arx;
         rword = fm_wr ? wword : m_mem[addr];
         n_fd  = rword[W-1:0];
         n_fp  = rword[W];
         bad   = (rword[W] != (($countones(rword[W-1:0]) % 2) == 0));
         n_fe  = bad ? 1'b1 : (fm_clr ? 1'b0 : m_fe);
      end
      @(posedge clk);
      #1;
      if (!reset_h && fm_wr) m_mem[addr] = wword;
      m_ar = n_ar; m_arx = n_arx; m_br = n_br; m_brx = n_brx; m_mq = n_mq;
      m_fd = n_fd; m_fp = n_fp; m_fe = n_fe;
   endtask

   task automatic idle();
      reset_h = 1'b0; ar_sel = '0; arx_sel = '0; mq_sel = '0; br_load = 1'b0;
      brx_load = 1'b0; ada_sel = '0; ada_dis = 1'b0; adb_sel = '0; boole = 1'b0;
      func = '0; cin = 1'b0; xcin = 1'b0; shin = 1'b0; mqin = 1'b0; fm_adr = '0;
      fm_blk = '0; fm_wr = 1'b0; fm_inj = 1'b0; fm_clr = 1'b0; ebus_drv = 1'b0;
      ebus_sel = '0;
   endtask

   task automatic rand_inputs();
      reset_h = ($urandom_range(0, 39) == 0);
      cache_s = W'($urandom); sh_s = W'($urandom); armm_s = W'($urandom); vma_s = W'($urandom);
      cache_l = {4'($urandom), 32'($urandom)}; sh_l = {4'($urandom), 32'($urandom)};
      armm_l = {4'($urandom), 32'($urandom)};  vma_l = {4'($urandom), 32'($urandom)};
      ar_sel = 3'($urandom); arx_sel = 2'($urandom); mq_sel = 2'($urandom);
      br_load = 1'($urandom); brx_load = 1'($urandom); ada_sel = 2'($urandom);
      ada_dis = ($urandom_range(0, 7) == 0); adb_sel = 2'($urandom); boole = 1'($urandom);
      func = 4'($urandom); cin = 1'($urandom); xcin = 1'($urandom); shin = 1'($urandom);
      mqin = 1'($urandom); fm_adr = 4'($urandom); fm_blk = 3'($urandom);
      fm_wr = ($urandom_range(0, 3) == 0); fm_inj = fm_wr && ($urandom_range(0, 3) == 0);
      fm_clr = ($urandom_range(0, 3) == 0); ebus_drv = 1'($urandom); ebus_sel = 3'($urandom);
   endtask

   initial begin
      idle();
      cache_s = '0; sh_s = '0; armm_s = '0; vma_s = '0;
      cache_l = '0; sh_l = '0; armm_l = '0; vma_l = '0;
      reset_h = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      m_ar = '0; m_arx = '0; m_br = '0; m_brx = '0; m_mq = '0;
      m_fd = '0; m_fp = 1'b0; m_fe = 1'b0;
      for (int i = 0; i < 128; i++) m_mem[i] = '0;
      cycle();
      // fill every FM word with clean parity
      for (int i = 0; i < 128; i++) begin
         idle();
         cache_s = W'($urandom); ar_sel = 3'd1; ada_sel = 2'($urandom);
         fm_blk = 3'(i / 16); fm_adr = 4'(i % 16); fm_wr = 1'b1;
         cycle();
      end

      // AR=3F + BR=01: wraps to zero with carry, no overflow
      idle(); cache_s = 6'h01; ar_sel = 3'd1; cycle();
      cache_s = 6'h3F; br_load = 1'b1; cycle();
      idle(); #1;
      check_eq("d_add_wrap_ad", ad, 6'h00);   check_eq("d_add_wrap_cout", cout, 1'b1);
      check_eq("d_add_wrap_eq0l", eq0_l, 1'b0); check_eq("d_add_wrap_ovf", ovf, 1'b0);
      cycle();
      // AR=1F + BR=01: signed overflow
      cache_s = 6'h1F; ar_sel = 3'd1; cycle();
      idle(); #1;
      check_eq("d_ovf_ad", ad, 6'h20); check_eq("d_ovf_flag", ovf, 1'b1);
      cycle();
      // boolean XOR of 2A and 0F
      cache_s = 6'h0F; ar_sel = 3'd1; cycle();
      cache_s = 6'h2A; br_load = 1'b1; cycle();
      idle(); boole = 1'b1; func = 4'h6; #1;
      check_eq("d_bool_xor", ad, 6'h25);
      cycle();
      // FM write 15 to block 3 adr 7 and read it back
      idle(); cache_s = 6'h15; ar_sel = 3'd1; cycle();
      idle(); boole = 1'b1; func = 4'hC; fm_blk = 3'd3; fm_adr = 4'd7; fm_wr = 1'b1; cycle();
      fm_wr = 1'b0; cycle();
      #1;
      check_eq("d_fm_data", fm_data, 6'h15); check_eq("d_fm_par", fm_par, 1'b0);
      check_eq("d_fm_err_clean", fm_err, 1'b0);
      // parity injection, sticky error, clear, set-wins-over-clear
      fm_wr = 1'b1; fm_inj = 1'b1; cycle();
      fm_wr = 1'b0; fm_inj = 1'b0; cycle();
      #1; check_eq("d_err_set", fm_err, 1'b1);
      fm_blk = 3'd0; fm_adr = 4'd0; cycle();
      #1; check_eq("d_err_hold", fm_err, 1'b1);
      fm_clr = 1'b1; cycle();
      #1; check_eq("d_err_clr", fm_err, 1'b0);
      fm_blk = 3'd3; fm_adr = 4'd7; cycle();
      #1; check_eq("d_err_set_wins", fm_err, 1'b1); check_eq("d_bad_par", fm_par, 1'b1);
      // MQ left shift in both widths
      idle(); cache_s = 6'h21; cache_l = 36'h8_0000_0021; ar_sel = 3'd1; cycle();
      idle(); boole = 1'b1; func = 4'hC; mq_sel = 2'd2; cycle();
      #1; check_eq("d_mq_load", mq, 6'h21); check_eq("d_mq36_load", l_mq, 36'h8_0000_0021);
      idle(); mq_sel = 2'd1; mqin = 1'b1; cycle();
      #1; check_eq("d_mq_shift", mq, 6'h03); check_eq("d_mq36_shift", l_mq, 36'h0_0000_0043);
      // reset overrides all loads and the FM write
      idle(); cache_s = 6'h2C; ar_sel = 3'd1; cycle();
      idle(); boole = 1'b1; func = 4'hC; fm_blk = 3'd5; fm_adr = 4'd2; fm_wr = 1'b1; cycle();
      reset_h = 1'b1; cache_s = 6'h3F; ar_sel = 3'd1; arx_sel = 2'd1; mq_sel = 2'd2;
      br_load = 1'b1; brx_load = 1'b1; func = 4'hF; cycle();
      idle(); #1;
      check_eq("d_rst_ar", ar, 6'h00);   check_eq("d_rst_arx", arx, 6'h00);
      check_eq("d_rst_br", br, 6'h00);   check_eq("d_rst_brx", brx, 6'h00);
      check_eq("d_rst_mq", mq, 6'h00);   check_eq("d_rst_fm", fm_data, 6'h00);
      check_eq("d_rst_err", fm_err, 1'b0);
      fm_blk = 3'd5; fm_adr = 4'd2; cycle();
      #1; check_eq("d_fm_survives_reset", fm_data, 6'h2C);

      // randomized phase against the model
      repeat (1500) begin
         rand_inputs();
         cycle();
      end
      idle();
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
